// File: rtl/mcu_el2_pkg.sv
// Shared types for the DCCM background ECC scrubber.
package mcu_el2_pkg;

  localparam int unsigned SCRUB_DW = 39;
  localparam int unsigned SCRUB_IW = 16;
  localparam int unsigned SCRUB_CW = 16;

  typedef enum logic [2:0] {
    SCRUB_IDLE,
    SCRUB_WAIT,
    SCRUB_RD_REQ,
    SCRUB_RD_WAIT,
    SCRUB_WB_REQ,
    SCRUB_ADV
  } mcu_el2_scrub_state_e;

  // ECC decode result for one returned read
  typedef struct packed {
    logic                sb;
    logic                db;
    logic [SCRUB_DW-1:0] data;
  } mcu_el2_scrub_rd_pkt_t;

  // Saturating increment for the error counter
  function automatic logic [SCRUB_CW-1:0] scrub_sat_inc(input logic [SCRUB_CW-1:0] v);
    return (v == {SCRUB_CW{1'b1}}) ? v : v + SCRUB_CW'(1);
  endfunction

endpackage

// File: rtl/mcu_el2_scrub_timer.sv
// Loadable down-counter pacing the scrubber between words.
module mcu_el2_scrub_timer
  import mcu_el2_pkg::*;
#(
  parameter int unsigned W = SCRUB_IW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load takes priority; decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mcu_el2_dccm_scrub_ctrl.sv
// Background DCCM ECC scrubber: read every word, write back single-bit corrections.
module mcu_el2_dccm_scrub_ctrl
  import mcu_el2_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 39
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scrub_en,
  input  logic [SCRUB_IW-1:0] scrub_interval,
  output logic                scrub_req,
  output logic                scrub_wr,
  output logic [AW-1:0]       scrub_addr,
  output logic [DW-1:0]       scrub_wr_data,
  input  logic                scrub_gnt,
  input  logic                rd_valid,
  input  logic                rd_sb_err,
  input  logic                rd_db_err,
  input  logic [DW-1:0]       rd_corr_data,
  input  logic                core_wr_en,
  input  logic [AW-1:0]       core_wr_addr,
  output logic [SCRUB_CW-1:0] sb_err_cnt,
  output logic                db_err,
  output logic [AW-1:0]       db_err_addr,
  output logic                pass_done,
  output logic                busy
);

  mcu_el2_scrub_state_e  state, state_d;
  mcu_el2_scrub_rd_pkt_t rd_pkt_c;

  logic                req_d, wr_d, db_err_d, pass_d, busy_d;
  logic                coll_flag, coll_d, coll_now_c;
  logic [AW-1:0]       addr_d, db_addr_d;
  logic [DW-1:0]       wr_data_d;
  logic [SCRUB_CW-1:0] cnt_d;
  logic                tmr_load, tmr_dec, tmr_zero_c;

  assign rd_pkt_c   = '{sb: rd_sb_err, db: rd_db_err, data: SCRUB_DW'(rd_corr_data)};
  assign coll_now_c = core_wr_en && (core_wr_addr == scrub_addr);

  mcu_el2_scrub_timer #(.W(SCRUB_IW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (scrub_interval),
    .dec      (tmr_dec),
    .zero_c   (tmr_zero_c)
  );

  // Next-state and next-output decode
  always_comb begin
    state_d   = state;
    addr_d    = scrub_addr;
    wr_data_d = scrub_wr_data;
    cnt_d     = sb_err_cnt;
    db_err_d  = 1'b0;
    db_addr_d = db_err_addr;
    pass_d    = 1'b0;
    coll_d    = coll_flag;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;

    case (state)
      SCRUB_IDLE: begin
        if (scrub_en) begin
          state_d  = SCRUB_WAIT;
          tmr_load = 1'b1;
        end
      end
      SCRUB_WAIT: begin
        if (!scrub_en) begin
          state_d = SCRUB_IDLE;
        end else if (tmr_zero_c) begin
          state_d = SCRUB_RD_REQ;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      SCRUB_RD_REQ: begin
        if (scrub_gnt) begin
          state_d = SCRUB_RD_WAIT;
          if (coll_now_c) coll_d = 1'b1;
        end
      end
      SCRUB_RD_WAIT: begin
        if (coll_now_c) coll_d = 1'b1;
        if (rd_valid) begin
          state_d = SCRUB_ADV;
          if (rd_pkt_c.db) begin
            db_err_d  = 1'b1;
            db_addr_d = scrub_addr;
          end else if (rd_pkt_c.sb) begin
            cnt_d = scrub_sat_inc(sb_err_cnt);
            // Core data written since the read is newer; skip the write-back
            if (!(coll_flag || coll_now_c)) begin
              wr_data_d = DW'(rd_pkt_c.data);
              state_d   = SCRUB_WB_REQ;
            end
          end
        end
      end
      SCRUB_WB_REQ: begin
        // A colliding core write beats a same-cycle grant
        if (coll_now_c) begin
          coll_d  = 1'b1;
          state_d = SCRUB_ADV;
        end else if (scrub_gnt) begin
          state_d = SCRUB_ADV;
        end
      end
      SCRUB_ADV: begin
        coll_d = 1'b0;
        if (scrub_addr == AW'(DEPTH - 1)) begin
          addr_d = '0;
          pass_d = 1'b1;
        end else begin
          addr_d = scrub_addr + AW'(1);
        end
        if (scrub_en) begin
          state_d  = SCRUB_WAIT;
          tmr_load = 1'b1;
        end else begin
          state_d = SCRUB_IDLE;
        end
      end
      default: state_d = SCRUB_IDLE;
    endcase

    req_d  = (state_d == SCRUB_RD_REQ) || (state_d == SCRUB_WB_REQ);
    wr_d   = (state_d == SCRUB_WB_REQ);
    busy_d = (state_d != SCRUB_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= SCRUB_IDLE;
      scrub_req     <= 1'b0;
      scrub_wr      <= 1'b0;
      scrub_addr    <= '0;
      scrub_wr_data <= '0;
      sb_err_cnt    <= '0;
      db_err        <= 1'b0;
      db_err_addr   <= '0;
      pass_done     <= 1'b0;
      busy          <= 1'b0;
      coll_flag     <= 1'b0;
    end else begin
      state         <= state_d;
      scrub_req     <= req_d;
      scrub_wr      <= wr_d;
      scrub_addr    <= addr_d;
      scrub_wr_data <= wr_data_d;
      sb_err_cnt    <= cnt_d;
      db_err        <= db_err_d;
      db_err_addr   <= db_addr_d;
      pass_done     <= pass_d;
      busy          <= busy_d;
      coll_flag     <= coll_d;
    end
  end

endmodule
